// File: rtl/myo_spi_responder.sv
// myo_spi_responder: oversampled mode-0 SPI slave for the myocontrol link; streams TX words out and delivers RX words.
`timescale 1ns/1ps
module myo_spi_responder #(
  parameter int WORD_BITS   = 16,
  parameter int FRAME_WORDS = 12
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sck,
  input  logic                 ss_n,
  input  logic                 mosi,
  output logic                 miso,
  output logic                 miso_oe,
  output logic                 tx_rd,
  output logic [3:0]           tx_index,
  input  logic [WORD_BITS-1:0] tx_data,
  output logic [WORD_BITS-1:0] rx_data,
  output logic [3:0]           rx_index,
  output logic                 rx_valid,
  output logic                 frame_done,
  output logic                 frame_error
);
  localparam int BW = $clog2(WORD_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(WORD_BITS - 1);
  localparam logic [4:0] FW = 5'(FRAME_WORDS);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  state_t state;
  logic [1:0] sck_s, ss_s, mosi_s;
  logic sck_p, ss_p, mosi_q, sck_rise, sck_fall, ss_fall, ss_rise;
  logic [BW-1:0] bit_cnt;
  logic [4:0] word_cnt, word_nxt;
  logic [WORD_BITS-1:0] tx_sr, rx_sr, hold, rx_nxt;
  assign word_nxt = word_cnt + 5'd1;
  assign rx_nxt = {rx_sr[WORD_BITS-2:0], mosi_q};
  // ss_n chain resets low so a frame already running at reset release cannot fake an ss_fall
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sck_s <= '0;
      ss_s <= '0;
      mosi_s <= '0;
      sck_p <= 1'b0;
      ss_p <= 1'b0;
      mosi_q <= 1'b0;
      sck_rise <= 1'b0;
      sck_fall <= 1'b0;
      ss_fall <= 1'b0;
      ss_rise <= 1'b0;
    end else begin
      sck_s <= {sck_s[0], sck};
      ss_s <= {ss_s[0], ss_n};
      mosi_s <= {mosi_s[0], mosi};
      sck_p <= sck_s[1];
      ss_p <= ss_s[1];
      mosi_q <= mosi_s[1];
      sck_rise <= sck_s[1] & ~sck_p;
      sck_fall <= ~sck_s[1] & sck_p;
      ss_fall <= ~ss_s[1] & ss_p;
      ss_rise <= ss_s[1] & ~ss_p;
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      miso <= 1'b0;
      miso_oe <= 1'b0;
      tx_rd <= 1'b0;
      tx_index <= '0;
      rx_data <= '0;
      rx_index <= '0;
      rx_valid <= 1'b0;
      frame_done <= 1'b0;
      frame_error <= 1'b0;
      bit_cnt <= '0;
      word_cnt <= '0;
      tx_sr <= '0;
      rx_sr <= '0;
      hold <= '0;
    end else begin
      tx_rd <= 1'b0;
      rx_valid <= 1'b0;
      frame_done <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        IDLE: begin
          miso_oe <= 1'b0;
          miso <= 1'b0;
          bit_cnt <= '0;
          word_cnt <= '0;
          if (ss_fall) begin
            tx_rd <= 1'b1;
            tx_index <= '0;
            state <= LOAD;
          end
        end
        LOAD: begin
          tx_sr <= tx_data;
          miso <= tx_data[WORD_BITS-1];
          miso_oe <= 1'b1;
          bit_cnt <= '0;
          word_cnt <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          if (tx_rd) hold <= tx_data;
          if (ss_rise) begin
            state <= IDLE;
            miso_oe <= 1'b0;
            miso <= 1'b0;
            frame_done <= bit_cnt == '0 && word_cnt == FW;
            frame_error <= !(bit_cnt == '0 && word_cnt == FW);
          end else if (sck_rise) begin
            rx_sr <= rx_nxt;
            bit_cnt <= bit_cnt == LAST_BIT ? '0 : bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              if (word_cnt < FW) begin
                rx_data <= rx_nxt;
                rx_index <= word_cnt[3:0];
                rx_valid <= 1'b1;
              end
              if (word_cnt <= FW) word_cnt <= word_nxt;
              if (word_nxt < FW) begin
                tx_rd <= 1'b1;
                tx_index <= word_nxt[3:0];
              end else hold <= '0;
            end
          end else if (sck_fall) begin
            tx_sr <= bit_cnt == '0 ? hold : {tx_sr[WORD_BITS-2:0], 1'b0};
            miso <= bit_cnt == '0 ? hold[WORD_BITS-1] : tx_sr[WORD_BITS-2];
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_myo_spi_responder.sv
// tb_myo_spi_responder: directed frames against a scoreboard of expected RX words and frame-end pulses.
`timescale 1ns/1ps
module tb_myo_spi_responder;
  logic clk = 0, reset_n, sck, ss_n, mosi;
  logic miso, miso_oe, tx_rd, rx_valid, frame_done, frame_error;
  logic [3:0] tx_index, rx_index;
  logic [15:0] tx_data, rx_data;
  logic [19:0] rx_q[$];
  logic end_q[$];
  int pass_cnt = 0, total_cnt = 0, done_cnt = 0, err_cnt = 0, tx_cnt = 0, tx_seq = 0;
  myo_spi_responder dut (
    .clk(clk), .reset_n(reset_n), .sck(sck), .ss_n(ss_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_rd(tx_rd), .tx_index(tx_index), .tx_data(tx_data),
    .rx_data(rx_data), .rx_index(rx_index), .rx_valid(rx_valid),
    .frame_done(frame_done), .frame_error(frame_error)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask
  task automatic flag(input string name, input logic [31:0] act);
    total_cnt++;
    $display("FAIL %s: unexpected output %h", name, act);
  endtask
  task automatic chk_reset();
    chk("rst_miso", miso, 0);
    chk("rst_miso_oe", miso_oe, 0);
    chk("rst_tx_rd", tx_rd, 0);
    chk("rst_tx_index", tx_index, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_index", rx_index, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_error", frame_error, 0);
  endtask
  // TX responder: the right word only in the cycle the DUT samples it, garbage otherwise
  initial begin
    tx_data = 16'hDEAD;
    forever begin
      @(posedge clk);
      #1 tx_data = tx_rd ? 16'h8000 + {12'h0, tx_index} : 16'hDEAD;
    end
  end
  initial begin
    logic e;
    logic [19:0] r;
    forever begin
      @(negedge clk);
      if (rx_valid) begin
        if (rx_q.size() == 0) flag("rx_spurious", {rx_index, rx_data});
        else begin
          r = rx_q.pop_front();
          chk("rx_word", {rx_index, rx_data}, r);
        end
      end
      if (frame_done | frame_error) begin
        if (end_q.size() == 0) flag("end_spurious", {frame_done, frame_error});
        else begin
          e = end_q.pop_front();
          chk("frame_end", {frame_done, frame_error}, e ? 2'b10 : 2'b01);
        end
      end
      if (frame_done) done_cnt++;
      if (frame_error) err_cnt++;
      if (tx_rd) begin
        chk("tx_index", tx_index, tx_seq);
        tx_seq++;
        tx_cnt++;
      end
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic send_word(input int w, input int nbits, input bit last_with_ss);
    logic [15:0] m, got;
    logic oe_ok;
    m = 16'h1230 + w[15:0];
    got = '0;
    oe_ok = 1;
    for (int b = 0; b < nbits; b++) begin
      mosi = m[15-b];
      repeat (5) @(negedge clk);
      got = {got[14:0], miso};
      if (!miso_oe) oe_ok = 0;
      sck = 1;
      if (b == 15 && w < 12) rx_q.push_back({w[3:0], m});
      repeat (5) @(negedge clk);
      if (last_with_ss && b == nbits - 1) ss_n = 1;
      sck = 0;
    end
    if (nbits == 16) begin
      chk("miso_word", got, w < 12 ? 16'h8000 + w[15:0] : 16'h0000);
      chk("miso_oe_word", oe_ok, 1);
    end
  endtask
  task automatic run_frame(input int nwords, input int part, input bit coincide);
    tx_seq = 0;
    ss_n = 0;
    repeat (4) @(negedge clk);
    chk("oe_early", miso_oe, 0);
    @(negedge clk);
    chk("oe_on", miso_oe, 1);
    repeat (3) @(negedge clk);
    for (int w = 0; w < nwords; w++) send_word(w, 16, coincide && part == 0 && w == nwords - 1);
    if (part > 0) send_word(nwords, part, 0);
    end_q.push_back(nwords == 12 && part == 0);
    if (!coincide) begin
      repeat (5) @(negedge clk);
      ss_n = 1;
    end
  endtask
  task automatic clr();
    done_cnt = 0;
    err_cnt = 0;
    tx_cnt = 0;
  endtask
  task automatic chk_counts(input string tag, input int d, input int e, input int t);
    chk({tag, "_done"}, done_cnt, d);
    chk({tag, "_error"}, err_cnt, e);
    chk({tag, "_tx_rd"}, tx_cnt, t);
  endtask
  initial begin
    sck = 0;
    ss_n = 1;
    mosi = 0;
    reset_n = 0;
    repeat (3) @(negedge clk);
    chk_reset();
    reset_n = 1;
    repeat (6) @(negedge clk);
    clr();
    run_frame(12, 0, 0);
    repeat (6) @(negedge clk);
    chk_counts("legal", 1, 0, 12);
    clr();
    run_frame(3, 7, 0);
    repeat (3) @(negedge clk);
    chk("short_oe_hold", miso_oe, 1);
    @(negedge clk);
    chk("short_oe_off", miso_oe, 0);
    repeat (3) @(negedge clk);
    chk_counts("short", 0, 1, 4);
    clr();
    run_frame(13, 0, 0);
    repeat (6) @(negedge clk);
    chk_counts("long", 0, 1, 12);
    tx_seq = 0;
    ss_n = 0;
    repeat (8) @(negedge clk);
    for (int w = 0; w < 5; w++) send_word(w, 16, 0);
    mosi = 1;
    sck = 1;
    repeat (3) @(negedge clk);
    reset_n = 0;
    #1;
    chk_reset();
    clr();
    repeat (3) @(negedge clk);
    reset_n = 1;
    sck = 0;
    repeat (4) begin
      repeat (5) @(negedge clk);
      sck = 1;
      repeat (5) @(negedge clk);
      sck = 0;
    end
    chk("relaunch_oe", miso_oe, 0);
    chk("relaunch_tx_rd", tx_cnt, 0);
    ss_n = 1;
    repeat (6) @(negedge clk);
    run_frame(12, 0, 0);
    repeat (6) @(negedge clk);
    chk_counts("after_reset", 1, 0, 12);
    clr();
    run_frame(12, 0, 0);
    repeat (4) @(negedge clk);
    run_frame(12, 0, 1);
    repeat (8) @(negedge clk);
    chk_counts("b2b", 2, 0, 24);
    chk("rx_q_left", rx_q.size(), 0);
    chk("end_q_left", end_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/myo_spi_responder.md
# myo_spi_responder

SPI slave that plays the motor-board end of the myocontrol SPI link: it answers the myocontrol master's MOSI/SCK/SS_n frames, returns status words (position, velocity, current, displacement) on MISO and delivers received command words to local logic. It sits inside muscle-board emulation and hardware-in-the-loop test builds on the DE10-Nano fabric. It is also the bench responder for the myocontrol master. It oversamples the SPI pins in the system clock domain; it generates no clock of its own.

## Interface

- `WORD_BITS`, default 16: bits per SPI word, sent and received MSB first.
- `FRAME_WORDS`, default 12: words in a legal frame; must be ≤ 15.
- `clk` in 1: system clock; must be ≥ 10× SCK frequency.
- `reset_n` in 1: asynchronous, active-low reset.
- `sck` in 1: SPI clock from master, mode 0 (CPOL=0, CPHA=0); asynchronous to `clk`.
- `ss_n` in 1: slave select, active low; asynchronous.
- `mosi` in 1: master data; asynchronous.
- `miso` out 1: slave data; valid only while `miso_oe`=1.
- `miso_oe` out 1: tri-state enable for the shared MISO line.
- `tx_rd` out 1: one-cycle request for the TX word at `tx_index`.
- `tx_index` out 4: word index requested by `tx_rd`.
- `tx_data` in WORD_BITS: TX word; sampled exactly one `clk` after `tx_rd`.
- `rx_data` out WORD_BITS: last received word; holds until the next `rx_valid`.
- `rx_index` out 4: index of `rx_data` within the frame.
- `rx_valid` out 1: one-cycle strobe marking a new `rx_data`.
- `frame_done` out 1: one-cycle pulse for a legal frame end.
- `frame_error` out 1: one-cycle pulse for an illegal frame end.

## Operation

- Input path: `sck`, `ss_n` and `mosi` each pass through a 2-FF synchronizer, then an edge-detect register. Detected events (sck_rise, sck_fall, ss_fall, ss_rise) are single-cycle.
- State machine IDLE → LOAD → SHIFT → IDLE:
  - IDLE: `miso_oe`=0 and the counters are cleared. On ss_fall, assert `tx_rd` with `tx_index`=0 and go to LOAD.
  - LOAD: one cycle. Capture `tx_data` into the TX shift register, drive its MSB on `miso`, set `miso_oe`=1, set bit_cnt=0 and word_cnt=0, then go to SHIFT.
  - SHIFT on sck_rise:
    - Shift the synced `mosi` into the RX shift register and increment bit_cnt.
    - When bit_cnt reaches WORD_BITS and word_cnt < FRAME_WORDS: the next cycle, `rx_data`=RX shift value, `rx_index`=word_cnt and `rx_valid`=1. In the same cycle, word_cnt is incremented and bit_cnt is cleared.
    - If the new word_cnt < FRAME_WORDS, assert `tx_rd` with `tx_index`=new word_cnt, and capture `tx_data` into a holding register one cycle later. Otherwise the holding register is loaded with 0.
  - SHIFT on sck_fall: if bit_cnt=0, move the holding register into the TX shift register and drive its MSB. Otherwise shift the TX register left and drive the next bit.
  - SHIFT on ss_rise: go to IDLE and set `miso_oe`=0. Pulse `frame_done` if bit_cnt=0 and word_cnt=FRAME_WORDS; otherwise pulse `frame_error`.
- Words beyond FRAME_WORDS: MISO sends 0x0000. No `rx_valid` and no `tx_rd` are issued. word_cnt saturates at FRAME_WORDS+1, so the frame ends in `frame_error`.
- A partial word at ss_rise is discarded: no `rx_valid`.
- ss_fall seen while not in IDLE is ignored. ss_rise has priority over an sck edge detected in the same cycle.
- Reset values: `miso`=0, `miso_oe`=0, `tx_rd`=0, `tx_index`=0, `rx_data`=0, `rx_index`=0, `rx_valid`=0, `frame_done`=0, `frame_error`=0, state=IDLE. Reset asserted mid-frame aborts immediately with no pulse. After reset is released, the block waits in IDLE for a fresh ss_fall; a frame already in progress at release is ignored until `ss_n` returns high.

## Timing

- Pin-to-event latency: 3 `clk` (2 synchronizer stages plus edge detect).
- `ss_n` pin low to first MISO bit valid with `miso_oe`=1: 5 `clk`. The master must wait ≥ 8 `clk` from `ss_n` low to the first SCK rise.
- SCK pin fall to next MISO bit: 4 `clk`. The ≥10× oversampling rule guarantees ≥ 1 `clk` of setup before the master samples on the SCK rise.
- `rx_valid`: 4 `clk` after the SCK pin rise carrying the word's last bit.
- `tx_rd` to `tx_data` sample: exactly 1 `clk`. The holding register is filled ≥ 3 `clk` before the next sck_fall.
- `ss_n` pin high to `miso_oe`=0 and the end pulse: 4 `clk`.
- Minimum `ss_n` high time between frames: 4 `clk`.

## Test plan

- Legal frame: `tx_data`=0x8000+index, master sends 12 words 0x1230+i at SCK = clk/10. Required: MISO carries 0x8000..0x800B, 12 `rx_valid` with `rx_data`=0x1230+i and `rx_index`=i, one `frame_done`, no `frame_error`.
- Short frame: `ss_n` rises after 7 bits of word 3. Required: `rx_valid` for words 0–2 only, one `frame_error`, `miso_oe`=0 4 `clk` after `ss_n` rises.
- Long frame: 13 words. Required: 12 `rx_valid`, the 13th MISO word is 0x0000, 12 `tx_rd` pulses, `frame_error`=1 at end.
- `tx_data` sampling: bench drives the correct word only in the cycle after `tx_rd` and garbage 0xDEAD at all other times. Required: MISO never shows 0xDEAD.
- Reset mid-frame: `reset_n` low during word 5. Required: all outputs at reset values immediately. After `ss_n` cycles high and a new 12-word frame runs, `frame_done`=1 with `rx_index` starting at 0.
- Back-to-back frames with 4 `clk` of `ss_n` high between them, plus an SCK edge coincident with `ss_n` rise. Required: two `frame_done` pulses and no spurious `rx_valid`.
